// File: rtl/posit_pkg.sv
// Shared constants, FSM encoding and helpers for the posit encoder.
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int POSIT_FW = POSIT_N - POSIT_ES - 3;
  localparam int SCALE_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

  // Width-generic special patterns (valid for n <= 64); callers size-cast to n bits.
  function automatic logic [63:0] nar_word(input int n);
    return 64'(1) << (n - 1);
  endfunction

  function automatic logic [63:0] maxpos_word(input int n);
    return nar_word(n) - 64'd1;
  endfunction

  localparam logic [POSIT_N-1:0] NAR    = POSIT_N'(nar_word(POSIT_N));
  localparam logic [POSIT_N-1:0] ZERO   = '0;
  localparam logic [POSIT_N-1:0] MAXPOS = POSIT_N'(maxpos_word(POSIT_N));
  localparam logic [POSIT_N-1:0] MINPOS = POSIT_N'(1);

endpackage

// File: rtl/posit_encoder_if.sv
// Request/result bundle between a requester (master) and the encoder (slave).
interface posit_encoder_if
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int FW = N - ES - 3
);

  logic                      encoder_start;
  logic                      sign_in;
  logic signed [SCALE_W-1:0] scale_in;
  logic [FW-1:0]             frac_in;
  logic                      zero_in;
  logic                      nar_in;
  logic [N-1:0]              posit_out;
  logic                      encode_done;
  logic                      busy;

  modport master (
    output encoder_start, sign_in, scale_in, frac_in, zero_in, nar_in,
    input  posit_out, encode_done, busy
  );

  modport slave (
    input  encoder_start, sign_in, scale_in, frac_in, zero_in, nar_in,
    output posit_out, encode_done, busy
  );

endinterface

// File: rtl/posit_round.sv
// Round-to-nearest-even of a 2N-bit MSB-aligned regime|e|frac field down to
// an (N-1)-bit magnitude, then clamp into [minpos, maxpos].
module posit_round
  import posit_pkg::*;
#(
  parameter int N = POSIT_N
) (
  input  logic [2*N-1:0] field,
  input  logic           sat_hi,
  input  logic           sat_lo,
  output logic [N-1:0]   mag
);

  localparam logic [N-1:0] MAXPOS_W = N'(maxpos_word(N));
  localparam logic [N-1:0] MINPOS_W = {{(N-1){1'b0}}, 1'b1};

  logic [N-2:0] top;
  logic         guard;
  logic         sticky;
  logic         rnd;
  logic [N-1:0] sum;

  // Round on guard/sticky, then clamp so a nonzero value never becomes 0 or NaR.
  always_comb begin
    top    = field[2*N-1:N+1];
    guard  = field[N];
    sticky = |field[N-1:0];
    rnd    = guard & (top[0] | sticky);
    sum    = {1'b0, top} + {{(N-1){1'b0}}, rnd};
    if (sat_hi)          mag = MAXPOS_W;
    else if (sat_lo)     mag = MINPOS_W;
    else if (sum[N-1])   mag = MAXPOS_W;
    else if (sum == '0)  mag = MINPOS_W;
    else                 mag = sum;
  end

endmodule

// File: rtl/posit_encoder.sv
// Multi-cycle posit encoder: captures sign/scale/fraction, packs the
// regime|exponent|fraction field, rounds, and presents the N-bit posit.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int FW = N - ES - 3
) (
  input  logic           clk,
  input  logic           rst,
  posit_encoder_if.slave bus
);

  localparam logic [N-1:0]       NAR_W    = N'(nar_word(N));
  localparam logic [N-1:0]       ZERO_W   = '0;
  localparam int                 SAT_LIM  = (N - 2) * (2 ** ES);
  localparam int                 PAD      = 2*N - 1 - ES - FW;
  localparam logic [SCALE_W:0]   RUN_MAX  = (SCALE_W+1)'(N - 1);
  localparam logic [SCALE_W:0]   RUN_ONE  = (SCALE_W+1)'(1);
  localparam logic [2*N-1:0]     ALL_ONES = '1;

  enc_state_t state_q, state_d;

  logic                      sign_q, zero_q, nar_q;
  logic signed [SCALE_W-1:0] scale_q;
  logic [FW-1:0]             frac_q;

  logic signed [SCALE_W-1:0] k;
  logic [ES-1:0]             e_bits;
  logic [SCALE_W:0]          run_raw, run_len;
  logic [2*N-1:0]            tail;
  logic [2*N-1:0]            field_d, field_q;
  logic                      sat_hi_d, sat_lo_d, sat_hi_q, sat_lo_q;

  logic [N-1:0]              mag;
  logic [N-1:0]              word_d;
  logic [N-1:0]              posit_q;
  logic                      is_busy, is_done;
  logic                      accept;

  assign accept = (state_q == IDLE) && bus.encoder_start;

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues.
  // NOTE: state_d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.encoder_start) state_d = (bus.nar_in || bus.zero_in) ? DONE : PACK;
      PACK:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    is_busy = (state_q != IDLE);
    is_done = (state_q == DONE);
  end

  // Capture the request when it is accepted.
  // NOTE: data registers are reset as well, so a reset leaves no stale operand behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      scale_q <= '0;
      frac_q  <= '0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
    end else if (accept) begin
      sign_q  <= bus.sign_in;
      scale_q <= bus.scale_in;
      frac_q  <= bus.frac_in;
      zero_q  <= bus.zero_in;
      nar_q   <= bus.nar_in;
    end
  end

  // Split scale into regime k and exponent e, then lay out regime|e|frac MSB-first.
  always_comb begin
    k      = scale_q >>> ES;
    e_bits = scale_q[ES-1:0];
    if (k[SCALE_W-1]) run_raw = -{k[SCALE_W-1], k};
    else              run_raw = {1'b0, k} + RUN_ONE;
    run_len  = (run_raw > RUN_MAX) ? RUN_MAX : run_raw;
    // Terminator is 0 after a run of ones (k>=0) and 1 after a run of zeros (k<0).
    tail     = {k[SCALE_W-1], e_bits, frac_q, {PAD{1'b0}}};
    field_d  = (k[SCALE_W-1] ? '0 : ~(ALL_ONES >> run_len)) | (tail >> run_len);
    sat_hi_d = int'(scale_q) > SAT_LIM;
    sat_lo_d = int'(scale_q) < -SAT_LIM;
  end

  // PACK stage register feeding the rounder.
  always_ff @(posedge clk) begin
    if (rst) begin
      field_q  <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else if (state_q == PACK) begin
      field_q  <= field_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  posit_round #(.N(N)) u_round (
    .field  (field_q),
    .sat_hi (sat_hi_q),
    .sat_lo (sat_lo_q),
    .mag    (mag)
  );

  // Apply the sign last; captured flags still win so the word is always consistent.
  always_comb begin
    if (nar_q)       word_d = NAR_W;
    else if (zero_q) word_d = ZERO_W;
    else             word_d = sign_q ? -mag : mag;
  end

  // Result register: loaded only on entry to DONE, so it holds between results.
  always_ff @(posedge clk) begin
    if (rst)                                              posit_q <= '0;
    else if (accept && (bus.nar_in || bus.zero_in))       posit_q <= bus.nar_in ? NAR_W : ZERO_W;
    else if (state_q == ROUND)                            posit_q <= word_d;
  end

  assign bus.posit_out   = posit_q;
  assign bus.encode_done = is_done;
  assign bus.busy        = is_busy;

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder: directed table, random ops against a
// bit-string reference model, and hand-written start/reset corner sequences.
module tb_posit_encoder;
  import posit_pkg::*;

  localparam int N  = POSIT_N;
  localparam int ES = POSIT_ES;
  localparam int FW = POSIT_FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  posit_encoder_if #(.N(N), .ES(ES), .FW(FW)) bus ();

  posit_encoder #(.N(N), .ES(ES), .FW(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: build the posit bit string in a queue, then round on the tail.
  function automatic logic [N-1:0] ref_encode(input logic s, input int scale,
                                              input logic [FW-1:0] f, input logic z, input logic n);
    bit     bits[$];
    int     useed_log, e, k, run;
    longint kept, mag, maxp;
    bit     guard, sticky;
    useed_log = 1 << ES;
    maxp      = (longint'(1) << (N - 1)) - 1;
    if (n) return NAR;
    if (z) return ZERO;
    if (scale > (N - 2) * useed_log)       mag = maxp;
    else if (scale < -(N - 2) * useed_log) mag = 1;
    else begin
      e = ((scale % useed_log) + useed_log) % useed_log;
      k = (scale - e) / useed_log;
      run = (k >= 0) ? k + 1 : -k;
      if (run > N - 1) run = N - 1;
      for (int i = 0; i < run; i++) bits.push_back(k >= 0);
      bits.push_back(k < 0);
      for (int i = ES - 1; i >= 0; i--) bits.push_back(((e >> i) & 1) == 1);
      for (int i = FW - 1; i >= 0; i--) bits.push_back(f[i]);
      kept = 0;
      for (int i = 0; i < N - 1; i++) kept = kept * 2 + ((i < bits.size()) ? longint'(bits[i]) : 0);
      guard  = (bits.size() > N - 1) ? bits[N-1] : 1'b0;
      sticky = 1'b0;
      for (int i = N; i < bits.size(); i++) sticky |= bits[i];
      mag = kept + ((guard && ((kept % 2 == 1) || sticky)) ? 1 : 0);
      if (mag > maxp) mag = maxp;
      if (mag == 0)   mag = 1;
    end
    return s ? N'(-mag) : N'(mag);
  endfunction

  typedef struct packed {
    logic                      sign;
    logic signed [SCALE_W-1:0] scale;
    logic [FW-1:0]             frac;
    logic                      zero;
    logic                      nar;
    logic [N-1:0]              word;
    logic [3:0]                lat;
  } vec_t;

  function automatic vec_t mk(input logic s, input int sc, input int f, input logic z,
                              input logic n, input logic [N-1:0] w, input int lat);
    vec_t v;
    v.sign = s; v.scale = SCALE_W'(sc); v.frac = FW'(f);
    v.zero = z; v.nar = n; v.word = w; v.lat = 4'(lat);
    return v;
  endfunction

  // One request: start pulse, wait (bounded) for done, verify busy/hold/pulse.
  task automatic run_op(input logic s, input int sc, input logic [FW-1:0] f, input logic z,
                        input logic n, output logic [N-1:0] word, output int lat);
    logic [N-1:0] held;
    bit busy_ok, hold_ok;
    @(negedge clk);
    bus.sign_in = s; bus.scale_in = SCALE_W'(sc); bus.frac_in = f;
    bus.zero_in = z; bus.nar_in = n; bus.encoder_start = 1'b1;
    held = bus.posit_out;
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.encoder_start = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.encode_done === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.posit_out !== held) hold_ok = 1'b0;
    end
    word = bus.posit_out;
    check("busy_while_working", 64'(busy_ok), 64'(1));
    check("posit_out_held", 64'(hold_ok), 64'(1));
    @(negedge clk);
    check("done_single_pulse", 64'(bus.encode_done), 64'(0));
    check("idle_after_done", 64'(bus.busy), 64'(0));
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.encode_done === 1'b1) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[24];
    logic [N-1:0] word, first_word;
    int           lat, pulses;
    logic         s, z, n;
    int           sc;
    logic [FW-1:0] f;

    vecs[0]  = mk(0,    0, 0,        0, 0, 32'h4000_0000, 3);
    vecs[1]  = mk(0,    1, 0,        0, 0, 32'h4800_0000, 3);
    vecs[2]  = mk(1,    0, 0,        0, 0, 32'hC000_0000, 3);
    vecs[3]  = mk(1,    5, 123,      1, 0, 32'h0000_0000, 1);
    vecs[4]  = mk(0,    0, 0,        1, 1, 32'h8000_0000, 1);
    vecs[5]  = mk(1,    0, 0,        0, 1, 32'h8000_0000, 1);
    vecs[6]  = mk(0,  200, 0,        0, 0, 32'h7FFF_FFFF, 3);
    vecs[7]  = mk(0, -200, 0,        0, 0, 32'h0000_0001, 3);
    vecs[8]  = mk(0,  120, 0,        0, 0, 32'h7FFF_FFFF, 3);
    vecs[9]  = mk(0,  121, 0,        0, 0, 32'h7FFF_FFFF, 3);
    vecs[10] = mk(0, -120, 0,        0, 0, 32'h0000_0001, 3);
    vecs[11] = mk(0, -121, 0,        0, 0, 32'h0000_0001, 3);
    vecs[12] = mk(0,   -1, 0,        0, 0, 32'h3800_0000, 3);
    vecs[13] = mk(0,    4, 0,        0, 0, 32'h6000_0000, 3);
    vecs[14] = mk(0,  118, 0,        0, 0, 32'h7FFF_FFFE, 3);
    vecs[15] = mk(0,  118, 1,        0, 0, 32'h7FFF_FFFF, 3);
    vecs[16] = mk(0,  117, 0,        0, 0, 32'h7FFF_FFFE, 3);
    vecs[17] = mk(0, -118, 0,        0, 0, 32'h0000_0002, 3);
    vecs[18] = mk(0, -119, 0,        0, 0, 32'h0000_0001, 3);
    vecs[19] = mk(1,  200, 0,        0, 0, 32'h8000_0001, 3);
    vecs[20] = mk(1, -200, 0,        0, 0, 32'hFFFF_FFFF, 3);
    vecs[21] = mk(0,    0, 1 << 26,  0, 0, 32'h4400_0000, 3);
    vecs[22] = mk(1,   -1, 0,        0, 0, 32'hC800_0000, 3);
    vecs[23] = mk(0, -117, 0,        0, 0, 32'h0000_0002, 3);

    bus.encoder_start = 1'b0; bus.sign_in = 1'b0; bus.scale_in = '0;
    bus.frac_in = '0; bus.zero_in = 1'b0; bus.nar_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_posit_out", 64'(bus.posit_out), 64'(0));
    check("reset_done", 64'(bus.encode_done), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 24; i++) begin
      run_op(vecs[i].sign, int'(vecs[i].scale), vecs[i].frac, vecs[i].zero, vecs[i].nar, word, lat);
      check($sformatf("vec%0d_word", i), 64'(word), 64'(vecs[i].word));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Start held high through PACK/ROUND/DONE with changed data: one result only.
    @(negedge clk);
    bus.sign_in = 1'b0; bus.scale_in = '0; bus.frac_in = '0;
    bus.zero_in = 1'b0; bus.nar_in = 1'b0; bus.encoder_start = 1'b1;
    pulses = 0; first_word = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.scale_in = SCALE_W'(4);
      if (bus.encode_done === 1'b1) begin
        if (pulses == 0) first_word = bus.posit_out;
        pulses++;
      end
    end
    @(negedge clk);
    bus.encoder_start = 1'b0;
    if (bus.encode_done === 1'b1) pulses++;
    count_done(8, lat);
    check("held_start_pulses", 64'(pulses + lat), 64'(1));
    check("held_start_word", 64'(first_word), 64'(32'h4000_0000));

    // Random requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      s  = 1'($urandom_range(0, 1));
      sc = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 260)) - 130
                                       : int'($urandom_range(0, 1023)) - 512;
      f  = FW'($urandom);
      z  = ($urandom_range(0, 15) == 0);
      n  = ($urandom_range(0, 15) == 0);
      run_op(s, sc, f, z, n, word, lat);
      check($sformatf("rand%0d_word s=%0d sc=%0d f=0x%0h z=%0d n=%0d", i, s, sc, f, z, n),
            64'(word), 64'(ref_encode(s, sc, f, z, n)));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'((z || n) ? 1 : 3));
    end

    // Reset two cycles after start aborts the operation.
    @(negedge clk);
    bus.sign_in = 1'b0; bus.scale_in = SCALE_W'(4); bus.frac_in = '0;
    bus.zero_in = 1'b0; bus.nar_in = 1'b0; bus.encoder_start = 1'b1;
    @(negedge clk);
    bus.encoder_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_posit_out", 64'(bus.posit_out), 64'(0));
    check("abort_done", 64'(bus.encode_done), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    count_done(6, pulses);
    check("abort_no_done", 64'(pulses), 64'(0));

    // Reset wins over a start in the same cycle.
    @(negedge clk);
    bus.scale_in = '0; bus.encoder_start = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.encoder_start = 1'b0; rst = 1'b0;
    check("rst_vs_start_busy", 64'(bus.busy), 64'(0));
    count_done(5, pulses);
    check("rst_vs_start_no_done", 64'(pulses), 64'(0));

    // Normal operation resumes after reset.
    run_op(1'b0, 1, '0, 1'b0, 1'b0, word, lat);
    check("post_reset_word", 64'(word), 64'(32'h4800_0000));
    check("post_reset_latency", 64'(lat), 64'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_encoder.md
POSIT_ENCODER -- requirements
Module: posit_encoder

Interface
REQ-001 SHALL have parameter N, default 32, meaning posit word width.
REQ-002 SHALL have parameter ES, default 2, meaning exponent field width.
REQ-003 SHALL have parameter FW, default N-ES-3, meaning fraction bits supplied (hidden bit excluded).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have port encoder_start  input  1  request pulse; sampled only in IDLE.
REQ-007 SHALL have port sign_in  input  1  result sign.
REQ-008 SHALL have port scale_in  input  10  signed two's-complement scale (k*2^ES + e).
REQ-009 SHALL have port frac_in  input  FW  normalised fraction, hidden 1 implied.
REQ-010 SHALL have port zero_in  input  1  force zero result.
REQ-011 SHALL have port nar_in  input  1  force NaR result.
REQ-012 SHALL have port posit_out  output  N  encoded result.
REQ-013 SHALL have port encode_done  output  1  one-cycle pulse; posit_out valid in that cycle.
REQ-014 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, PACK, ROUND and DONE.
REQ-016 SHALL, in IDLE with encoder_start=1, register all data inputs and flags; next state is DONE if nar_in or zero_in, else PACK.
REQ-017 SHALL, in PACK, compute k = scale >>> ES (floor) and e = scale mod 2^ES, then build sign-less word regime|e|frac in a 2N-bit field, MSB-aligned.
REQ-018 SHALL form the regime for k>=0 as k+1 ones then a zero, and for k<0 as -k zeros then a one, with run length capped at N-1.
REQ-019 SHALL, in ROUND, take the top N-1 bits and round to nearest, ties to even, using guard bit and OR of remaining bits.
REQ-020 SHALL clamp a nonzero magnitude to the range [minpos=1, maxpos=2^(N-1)-1]; rounding never yields 0 or NaR.
REQ-021 SHALL saturate scale_in > (N-2)*2^ES to maxpos and scale_in < -(N-2)*2^ES to minpos.
REQ-022 SHALL apply sign_in=1 as the two's complement of the N-bit word at the end of ROUND.
REQ-023 SHALL, in DONE, assert encode_done=1 for exactly one cycle, update posit_out, and move to IDLE next cycle.
REQ-024 SHALL set posit_out to 1 followed by N-1 zeros (NaR) when nar_in; NaR takes priority over zero_in; zero_in gives all zeros; sign_in is ignored in both cases.
REQ-025 SHALL give a latency, with encoder_start at cycle T, of encode_done at T+3 for the normal path and at T+1 for the special path.
REQ-026 SHALL ignore encoder_start while busy=1, with no queuing; encoder_start in the same cycle as encode_done is also ignored.
REQ-027 SHALL hold posit_out stable from encode_done until the next encode_done.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, force state IDLE, posit_out=0, encode_done=0, busy=0 and clear captured registers.
REQ-029 SHALL abort any in-flight operation on rst asserted mid-operation, with no encode_done produced for it.
REQ-030 SHALL take precedence for rst over encoder_start in the same cycle.

Structure
REQ-031 SHALL place N, ES, the FSM state encoding, and the NAR, ZERO and MAXPOS/MINPOS constants in shared package posit_pkg.
REQ-032 SHALL implement rounding plus clamping (REQ-019/020) in combinational sub-module posit_round, instantiated once.

Verification
REQ-033 SHALL verify: start, sign 0, scale 0, frac 0 -> posit_out 0x40000000 with encode_done at T+3.
REQ-034 SHALL verify: sign 0, scale 1, frac 0 -> 0x48000000; sign 1, scale 0, frac 0 -> 0xC0000000.
REQ-035 SHALL verify: zero_in=1 -> 0x00000000 at T+1; zero_in=1 and nar_in=1 -> 0x80000000 at T+1.
REQ-036 SHALL verify: scale 200 -> 0x7FFFFFFF; scale -200 -> 0x00000001.
REQ-037 SHALL verify: second encoder_start at T+1 is ignored (single done pulse); rst at T+2 -> no done, all outputs 0.
